fp8_add_arbiter: RTL and testbench
==================================

# fp8_add_arbiter

Round-robin arbiter that shares one `adder_fp8` instance between `NUM_REQ` independent requesters. Each requester presents an operand pair over a valid/ready handshake. The block grants one requester per cycle, drives the granted operands into the shared adder, and returns the sum tagged with the requester index through a registered, back-pressurable response port. It sits between the vector/scalar issue logic and the FP8 adder datapath.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `IMPL_TYPE`, default 0: passed unchanged to the `adder_fp8` instance.
- `ID_W`, default `$clog2(NUM_REQ)` (minimum 1): width of the response tag.

**Ports** (one clock; reset is synchronous and active-high)
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NUM_REQ: bit i means requester i has an operand pair pending.
- `req_ready`, output, NUM_REQ: one-hot or zero; bit i means requester i is accepted this cycle.
- `req_a`, input, NUM_REQ*8: operand A; requester i uses bits [8i+7:8i].
- `req_b`, input, NUM_REQ*8: operand B, same packing as `req_a`.
- `rsp_valid`, output, 1: response register holds a result.
- `rsp_ready`, input, 1: downstream accepts the response.
- `rsp_id`, output, ID_W: index of the requester that owns `rsp_result`.
- `rsp_result`, output, 8: FP8 sum (1 sign, 3 exponent, 4 mantissa).

## Operation

**Handshake**
- A request transfers when `req_valid[i] && req_ready[i]`.
- A response transfers when `rsp_valid && rsp_ready`.
- Requesters must hold `req_a`/`req_b` stable while valid and not yet accepted.

**Space rule**
- `can_accept = !rsp_valid || rsp_ready` (default build).
- `req_ready` is all-zero when `!can_accept`.

**Arbitration**
- Round-robin pointer `rr_ptr`, ID_W bits.
- The grant goes to the first valid requester at or after `rr_ptr`, wrapping modulo NUM_REQ.
- On an accepted request from requester g, `rr_ptr` becomes (g+1) mod NUM_REQ.
- With no acceptance, `rr_ptr` holds.
- `req_ready` never depends on `rsp_ready` through any path other than `can_accept`.

**Datapath**
- The granted pair is muxed combinationally into the single `adder_fp8`.
- The adder output and grant index are captured in `rsp_result`/`rsp_id` on acceptance.
- The result is passed through bit-exact, including the NaN (0x78), infinity (0x70/0xF0) and zero encodings.

**Response register states**
- EMPTY → FULL on acceptance.
- FULL → EMPTY when the response transfers with no new acceptance.
- FULL → FULL when the response transfers and a new request is accepted in the same cycle; the register reloads with the new value.
- FULL with `!rsp_ready`: contents and `rsp_id` held stable.

**Reset**
- Outputs: `rsp_valid`=0, `rsp_result`=8'h00, `rsp_id`=0, `req_ready`=0.
- `rr_ptr`=0.
- Reset asserted mid-transfer discards any held result, and the result is never presented.

**Degenerate case**
- NUM_REQ=1 means no arbitration: `req_ready = req_valid && can_accept`.

## Timing

- Latency from acceptance to `rsp_valid` is 1 cycle in the default build.
- Throughput is one operation per cycle when `rsp_ready` is held high.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `rsp_valid` and `rsp_ready`.
- All other outputs come directly from flops.
- The adder is purely combinational between the grant mux and the response register.

## Configuration

- `FP8_ADD_ARB_OPREG_EN` defined:
  - Adds an operand register stage (`op_valid`, `op_a`, `op_b`, `op_id`) between the grant mux and the adder, giving a 2-stage pipeline.
  - Latency is 2 cycles.
  - Acceptance rule becomes `!op_valid || (!rsp_valid || rsp_ready)`.
  - Each stage advances only when the stage downstream of it has space.
  - Full throughput is retained.
  - Reset clears `op_valid`.
- Not defined: the single-stage behaviour described above.

## Structure

- Package `fp8_pkg`:
  - `FP8_W = 8`
  - typedef `fp8_t` (logic [7:0])
  - constants `FP8_QNAN = 8'h78`, `FP8_POS_INF = 8'h70`, `FP8_NEG_INF = 8'hF0`
- Sub-module `rr_arbiter`, parameter N:
  - inputs: `req`, `ptr`
  - outputs: one-hot `gnt`, encoded `gnt_idx`, `any_gnt`
  - purely combinational
  - `rr_ptr` stays in the parent.
- One `adder_fp8` instance inside `fp8_add_arbiter`.

## Test plan

- **Single request:** requester 2 sends a=0x30, b=0x30 with `rsp_ready`=1 → `rsp_valid` the next cycle, `rsp_result`=0x40, `rsp_id`=2.
- **Fairness:** all 4 requesters valid continuously with `rsp_ready`=1 → grants 0,1,2,3,0,1,…, one per cycle, no bubbles.
- **Backpressure:** `rsp_ready`=0 while FULL → `req_ready`=0, `rsp_result`/`rsp_id` stable across 5 cycles. Raising `rsp_ready` transfers the held result and accepts the next request in the same cycle.
- **Special values:**
  - a=0x70, b=0xF0 → 0x78.
  - a=0x70, b=0x30 → 0x70.
  - a=0x00, b=0x00 → 0x00.
- **Reset mid-operation:** `rst` pulsed while FULL with `rsp_ready`=0 → the next cycle shows `rsp_valid`=0 and `rr_ptr`=0. After release with requesters 1 and 3 valid, the first grant goes to 1.
- **`FP8_ADD_ARB_OPREG_EN` build:** the fairness scenario repeated → identical grant order and results, each response 2 cycles after acceptance, and no lost or duplicated responses under random `rsp_ready`.

Source files
------------

// File: rtl/fp8_pkg.sv
// fp8_pkg: shared FP8 definitions for the FP8 adder datapath.
//   FP8 format: 1 sign, 3 exponent (bias 3), 4 mantissa.
//   Exponent 0 encodes zero/subnormals, exponent 7 encodes inf (mantissa 0) or NaN.
//   Contents: FP8_W, fp8_t, canonical NaN/inf constants, classification helpers.
package fp8_pkg;

  localparam int FP8_W = 8;

  typedef logic [FP8_W-1:0] fp8_t;

  localparam fp8_t FP8_QNAN    = 8'h78;
  localparam fp8_t FP8_POS_INF = 8'h70;
  localparam fp8_t FP8_NEG_INF = 8'hF0;

  function automatic logic fp8_is_nan(input fp8_t x);
    return (x[6:4] == 3'b111) && (x[3:0] != 4'd0);
  endfunction

  function automatic logic fp8_is_inf(input fp8_t x);
    return (x[6:4] == 3'b111) && (x[3:0] == 4'd0);
  endfunction

endpackage

// File: rtl/adder_fp8.sv
// adder_fp8: combinational FP8 adder, round-to-nearest-even.
//   Ports: a, b - FP8 operands; sum - FP8 result.
//   Every finite FP8 value is an integer multiple of 2^-6, so both operands are
//   converted to exact signed integers in that unit, added exactly, and the sum
//   is renormalised with a single rounding step. Overflow goes to infinity,
//   any NaN or inf-inf yields the canonical NaN 0x78.
//   IMPL_TYPE 0 feeds operands straight through; other values feed them in
//   swapped order (the result is identical because the sum is exact).
import fp8_pkg::*;

module adder_fp8 #(
  parameter int IMPL_TYPE = 0
) (
  input  fp8_t a,
  input  fp8_t b,
  output fp8_t sum
);

  // Magnitude in units of 2^-6 for finite encodings.
  function automatic logic [10:0] to_units(input fp8_t x);
    if (x[6:4] == 3'd0) return {7'd0, x[3:0]};
    return {6'd0, 1'b1, x[3:0]} << (x[6:4] - 3'd1);
  endfunction

  // Renormalise an exact magnitude (2^-6 units) with round-to-nearest-even.
  function automatic fp8_t round_fp8(input logic sign, input logic [10:0] mag);
    int         p;
    int         sh;
    int         e;
    logic [4:0]  mant;
    logic [10:0] rem;
    logic [10:0] half;
    logic [5:0]  m6;
    logic        rup;
    if (mag < 11'd16) return {sign, 3'd0, mag[3:0]};
    p = 4;
    for (int i = 4; i < 11; i++) if (mag[i]) p = i;
    sh   = p - 4;
    mant = 5'(mag >> sh);
    rem  = mag & ((11'd1 << sh) - 11'd1);
    half = (sh == 0) ? 11'd0 : (11'd1 << (sh - 1));
    rup  = (sh != 0) && ((rem > half) || ((rem == half) && mant[0]));
    m6   = {1'b0, mant} + {5'd0, rup};
    e    = p - 3;
    // Mantissa carry-out moves into the next binade.
    if (m6[5]) begin
      e  = e + 1;
      m6 = 6'd0;
    end
    if (e >= 7) return sign ? FP8_NEG_INF : FP8_POS_INF;
    return {sign, e[2:0], m6[3:0]};
  endfunction

  function automatic fp8_t add_fp8(input fp8_t x, input fp8_t y);
    logic signed [11:0] vx;
    logic signed [11:0] vy;
    logic signed [11:0] vs;
    logic [10:0]        mag;
    if (fp8_is_nan(x) || fp8_is_nan(y) ||
        (fp8_is_inf(x) && fp8_is_inf(y) && (x[7] != y[7]))) return FP8_QNAN;
    if (fp8_is_inf(x)) return x;
    if (fp8_is_inf(y)) return y;
    vx = x[7] ? -$signed({1'b0, to_units(x)}) : $signed({1'b0, to_units(x)});
    vy = y[7] ? -$signed({1'b0, to_units(y)}) : $signed({1'b0, to_units(y)});
    vs = vx + vy;
    // An exact zero is negative only when both inputs were negative zeros.
    if (vs == 12'sd0) return {x[7] & y[7], 7'd0};
    mag = vs[11] ? 11'(-vs) : vs[10:0];
    return round_fp8(vs[11], mag);
  endfunction

  if (IMPL_TYPE == 0) begin : g_direct
    assign sum = add_fp8(a, b);
  end else begin : g_swapped
    assign sum = add_fp8(b, a);
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant selection.
//   Ports: req     - request vector, one bit per requester
//          ptr     - index with highest priority this cycle
//          gnt     - one-hot grant (zero when nothing requests)
//          gnt_idx - encoded index of the granted requester
//          any_gnt - at least one requester granted
//   The pointer register itself lives in the parent.
import fp8_pkg::*;

module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any_gnt
);

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    j       = 0;
    // Scan starting at ptr and wrap; the first requester found wins.
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any_gnt && req[j]) begin
        any_gnt = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp8_add_arbiter.sv
// fp8_add_arbiter: round-robin sharing of one adder_fp8 between NUM_REQ requesters.
//   Ports: clk, rst (synchronous, active-high)
//          req_valid/req_ready - per-requester handshake (req_ready one-hot or zero)
//          req_a/req_b         - packed operands, requester i at [8i+7:8i]
//          rsp_valid/rsp_ready - registered response handshake
//          rsp_id/rsp_result   - owner index and FP8 sum
//   Build option FP8_ADD_ARB_OPREG_EN: adds an operand register stage in front
//   of the adder (2-cycle latency, full throughput). Undefined: 1-cycle latency.
import fp8_pkg::*;

module fp8_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IMPL_TYPE = 0,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_gnt;
  logic               rsp_space;
  logic               can_accept;
  logic               accept;
  logic               rsp_load;
  fp8_t               a_p0;
  fp8_t               b_p0;
  fp8_t               add_a;
  fp8_t               add_b;
  logic [ID_W-1:0]    add_id;
  fp8_t               sum;

  // Stage p0: grant and operand mux
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign rsp_space = !rsp_valid || rsp_ready;
  assign a_p0      = req_a[int'(gnt_idx)*8 +: 8];
  assign b_p0      = req_b[int'(gnt_idx)*8 +: 8];
  assign accept    = any_gnt && can_accept;
  assign req_ready = can_accept ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
    end
  end

`ifdef FP8_ADD_ARB_OPREG_EN
  logic            op_valid;
  fp8_t            op_a;
  fp8_t            op_b;
  logic [ID_W-1:0] op_id;
  logic            op_adv;

  // Reset blocks acceptance so nothing is handed off while state is discarded.
  assign can_accept = !rst && (!op_valid || rsp_space);
  assign op_adv     = op_valid && rsp_space;

  // Stage p1: operand register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid <= 1'b0;
    end else if (accept) begin
      op_valid <= 1'b1;
    end else if (op_adv) begin
      op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_a  <= a_p0;
      op_b  <= b_p0;
      op_id <= gnt_idx;
    end
  end

  assign add_a    = op_a;
  assign add_b    = op_b;
  assign add_id   = op_id;
  assign rsp_load = op_adv;
`else
  assign can_accept = !rst && rsp_space;
  assign add_a      = a_p0;
  assign add_b      = b_p0;
  assign add_id     = gnt_idx;
  assign rsp_load   = accept;
`endif

  adder_fp8 #(.IMPL_TYPE(IMPL_TYPE)) u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (sum)
  );

  // Response register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_id     <= '0;
    end else if (rsp_load) begin
      rsp_valid  <= 1'b1;
      rsp_result <= sum;
      rsp_id     <= add_id;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// tb_fp8_add_arbiter: self-checking bench for fp8_add_arbiter (NUM_REQ=4).
//   Reference adder works on real values and picks the nearest FP8 code by
//   searching all encodings; the arbiter reference tracks pending requests,
//   a priority pointer and an in-flight queue.
module tb_fp8_add_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef FP8_ADD_ARB_OPREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         id;
    logic [7:0] res;
    int         cyc;
  } exp_t;
  exp_t q[$];

  fp8_add_arbiter #(.NUM_REQ(N), .IMPL_TYPE(0), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic real dec_mag(input logic [6:0] c);
    if (c[6:4] == 3'd0) return real'(c[3:0]) / 64.0;
    return real'(16 + c[3:0]) * real'(1 << c[6:4]) / 128.0;
  endfunction

  function automatic logic [7:0] ref_add(input logic [7:0] x, input logic [7:0] y);
    bit         xn, yn, xi, yi;
    real        v, mag, best_d, d;
    logic [6:0] best;
    xn = (x[6:4] == 3'b111) && (x[3:0] != 0);
    yn = (y[6:4] == 3'b111) && (y[3:0] != 0);
    xi = (x[6:4] == 3'b111) && (x[3:0] == 0);
    yi = (y[6:4] == 3'b111) && (y[3:0] == 0);
    if (xn || yn || (xi && yi && x[7] != y[7])) return 8'h78;
    if (xi) return x;
    if (yi) return y;
    v = (x[7] ? -1.0 : 1.0) * dec_mag(x[6:0]) + (y[7] ? -1.0 : 1.0) * dec_mag(y[6:0]);
    if (v == 0.0) return {x[7] & y[7], 7'h00};
    mag = (v < 0.0) ? -v : v;
    if (mag >= 15.75) return (v < 0.0) ? 8'hF0 : 8'h70;
    best = 7'd0;
    best_d = 1.0e9;
    for (int c = 0; c < 'h70; c++) begin
      d = dec_mag(7'(c)) - mag;
      if (d < 0.0) d = -d;
      if (d < best_d || (d == best_d && c[0] == 1'b0)) begin
        best_d = d;
        best = 7'(c);
      end
    end
    return {v < 0.0, best};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    tick(); tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_result !== 8'h00) begin failures++; $display("FAIL reset_rsp_result got=%0h exp=0", rsp_result); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
    rst = 1'b0; req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL idle_req_ready got=%0h exp=0", req_ready); end
    tick();
  endtask

  task automatic test_single();
    pulse_reset();
    rsp_ready = 1'b1;
    req_a[23:16] = 8'h30; req_b[23:16] = 8'h30;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%0h exp=4", req_ready); end
    tick();
    req_valid = '0;
    repeat (LAT - 1) tick();
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_result !== 8'h40) begin failures++; $display("FAIL single_result got=%0h exp=40", rsp_result); end
    checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0h exp=2", rsp_id); end
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0h exp=0", rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_r;
    exp_t       e;
    pulse_reset();
    q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = 8'($urandom);
      req_b[i*8 +: 8] = 8'($urandom);
    end
    req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_r = 4'(1 << (k % N));
      checks++; if (req_ready !== exp_r) begin failures++; $display("FAIL fair_grant k=%0d got=%0h exp=%0h", k, req_ready, exp_r); end
      if (k >= LAT) begin
        e = q.pop_front();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e.id) || rsp_result !== e.res) begin
          failures++; $display("FAIL fair_rsp k=%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, rsp_valid, rsp_id, rsp_result, e.id, e.res);
        end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL fair_early k=%0d got=%0h exp=0", k, rsp_valid); end
      end
      q.push_back('{id: k % N, res: ref_add(req_a[(k%N)*8 +: 8], req_b[(k%N)*8 +: 8]), cyc: k});
      tick();
      req_a[(k%N)*8 +: 8] = 8'($urandom);
      req_b[(k%N)*8 +: 8] = 8'($urandom);
    end
    req_valid = '0;
    while (q.size() > 0) begin
      #1;
      e = q.pop_front();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e.id) || rsp_result !== e.res) begin
        failures++; $display("FAIL fair_tail got=%0h/%0h/%0h exp=1/%0h/%0h", rsp_valid, rsp_id, rsp_result, e.id, e.res);
      end
      tick();
    end
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL fair_empty got=%0h exp=0", rsp_valid); end
  endtask

  task automatic test_special();
    logic [7:0] sa [3];
    logic [7:0] sb [3];
    logic [7:0] sr [3];
    sa = '{8'h70, 8'h70, 8'h00};
    sb = '{8'hF0, 8'h30, 8'h00};
    sr = '{8'h78, 8'h70, 8'h00};
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_a[7:0] = sa[i]; req_b[7:0] = sb[i];
      req_valid = 4'b0001;
      #1;
      tick();
      req_valid = '0;
      repeat (LAT - 1) tick();
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== sr[i]) begin
        failures++; $display("FAIL special_%0d got=%0h/%0h exp=1/%0h", i, rsp_valid, rsp_result, sr[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    rsp_ready = 1'b0;
    req_a[15:8] = 8'h70; req_b[15:8] = 8'h30;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_ready got=%0h exp=2", req_ready); end
    tick();
    req_valid = '0;
`ifdef FP8_ADD_ARB_OPREG_EN
    tick();
`endif
    req_a[31:24] = 8'h00; req_b[31:24] = 8'h00;
    req_valid = 4'b1000;
`ifdef FP8_ADD_ARB_OPREG_EN
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_op_fill got=%0h exp=8", req_ready); end
    tick();
    req_valid = '0;
`endif
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h70 || rsp_id !== 2'd1) begin
        failures++; $display("FAIL bp_hold c=%0d got=%0h/%0h/%0h exp=1/70/1", c, rsp_valid, rsp_result, rsp_id);
      end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_low c=%0d got=%0h exp=0", c, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
`ifdef FP8_ADD_ARB_OPREG_EN
    req_a[7:0] = 8'h30; req_b[7:0] = 8'h30;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_release_ready got=%0h exp=1", req_ready); end
`else
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%0h exp=8", req_ready); end
`endif
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h00 || rsp_id !== 2'd3) begin
      failures++; $display("FAIL bp_next got=%0h/%0h/%0h exp=1/0/3", rsp_valid, rsp_result, rsp_id);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    rsp_ready = 1'b0;
    req_a[7:0] = 8'h30; req_b[7:0] = 8'h30;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (LAT - 1) tick();
    #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rm_full got=%0h exp=1", rsp_valid); end
    rst = 1'b1;
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rm_ready_in_reset got=%0h exp=0", req_ready); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 8'h00) begin
      failures++; $display("FAIL rm_cleared got=%0h/%0h exp=0/0", rsp_valid, rsp_result);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_never_presented c=%0d got=%0h exp=0", c, rsp_valid); end
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rm_first_grant got=%0h exp=2", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rm_second_grant got=%0h exp=8", req_ready); end
    tick();
    req_valid = '0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    logic [3:0]   exp_r;
    int           m_ptr, g, j;
    bit           rv, can, drain;
    pulse_reset();
    q.delete();
    pending = '0;
    m_ptr = 0;
    for (int t = 0; t < 420; t++) begin
      drain = (t >= 400);
      for (int i = 0; i < N; i++) begin
        if (!drain && !pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
        end
      end
      req_valid = pending;
      rsp_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      rv = (q.size() > 0) && (q[0].cyc + LAT <= t);
      checks++; if (rsp_valid !== rv) begin failures++; $display("FAIL rand_valid t=%0d got=%0h exp=%0h", t, rsp_valid, rv); end
      if (rv) begin
        checks++; if (rsp_id !== 2'(q[0].id) || rsp_result !== q[0].res) begin
          failures++; $display("FAIL rand_rsp t=%0d got=%0h/%0h exp=%0h/%0h", t, rsp_id, rsp_result, q[0].id, q[0].res);
        end
      end
      can = (q.size() < LAT) || rsp_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && pending[j]) g = j;
      end
      exp_r = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++; if (req_ready !== exp_r) begin failures++; $display("FAIL rand_ready t=%0d got=%0h exp=%0h", t, req_ready, exp_r); end
      if (rv && rsp_ready) void'(q.pop_front());
      if (can && g >= 0) begin
        q.push_back('{id: g, res: ref_add(req_a[g*8 +: 8], req_b[g*8 +: 8]), cyc: t});
        pending[g] = 1'b0;
        m_ptr = (g + 1) % N;
      end
      tick();
    end
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rand_final_empty got=%0h exp=0", rsp_valid); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_fairness();
    test_special();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
